// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore sample path: request encodings,
// dispatcher holding-buffer states and default array dimensions.
package multicore_pkg;

    localparam int unsigned DEFAULT_N_CORES = 41;
    localparam int unsigned DEFAULT_DW      = 32;

    localparam logic [1:0] REQ_IDLE   = 2'b00;
    localparam logic [1:0] REQ_URGENT = 2'b11;

    typedef enum logic {
        EMPTY,
        FULL
    } disp_state_t;

    // 01 and 10 are both plain (non-urgent) requests
    function automatic logic is_normal(input logic [1:0] r);
        return (r != REQ_IDLE) && (r != REQ_URGENT);
    endfunction

endpackage

// File: rtl/sample_dispatcher_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first eligible
// index at or above ptr, wrapping to the lowest eligible index below ptr.
module rr_pick #(
    parameter int unsigned N     = 41,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Split search into the upper (>= ptr) and wrapped (< ptr) halves
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i]) begin
                if (IDX_W'(i) >= ptr) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = IDX_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        found = hi_found | lo_found;
        idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/sample_dispatcher.sv
// sample_dispatcher: holds one sample from the source and grants it to one
// requesting core per cycle using two-class (urgent/normal) round-robin.
// Optional statistics counters: define SAMPLE_DISPATCHER_STATS_EN.
module sample_dispatcher
    import multicore_pkg::*;
#(
    parameter int unsigned N_CORES = DEFAULT_N_CORES,
    parameter int unsigned DW      = DEFAULT_DW,
    parameter int unsigned IDX_W   = $clog2(N_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*N_CORES-1:0] req_in,
    input  logic [DW-1:0]        src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic [DW-1:0]        core_data,
    output logic [N_CORES-1:0]   core_grant,
    output logic [IDX_W-1:0]     grant_idx
`ifdef SAMPLE_DISPATCHER_STATS_EN
    ,
    output logic [31:0]          stat_dispatched,
    output logic [31:0]          stat_starve
`endif
);

    disp_state_t          state;
    logic [DW-1:0]        buf_q;
    logic [IDX_W-1:0]     u_ptr;
    logic [IDX_W-1:0]     n_ptr;
    logic [N_CORES-1:0]   urg_elig;
    logic [N_CORES-1:0]   norm_elig;
    logic                 u_found;
    logic                 n_found;
    logic [IDX_W-1:0]     u_idx;
    logic [IDX_W-1:0]     n_idx;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     ptr_next;
    logic [N_CORES-1:0]   grant_next;
    logic                 fire;

    // Per-class eligibility; the registered grant doubles as the lockout mask
    always_comb begin
        urg_elig  = '0;
        norm_elig = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            urg_elig[i]  = (req_in[2*i +: 2] == REQ_URGENT) && !core_grant[i];
            norm_elig[i] = is_normal(req_in[2*i +: 2]) && !core_grant[i];
        end
    end

    rr_pick #(.N(N_CORES), .IDX_W(IDX_W)) u_pick_urgent (
        .eligible (urg_elig),
        .ptr      (u_ptr),
        .found    (u_found),
        .idx      (u_idx)
    );

    rr_pick #(.N(N_CORES), .IDX_W(IDX_W)) u_pick_normal (
        .eligible (norm_elig),
        .ptr      (n_ptr),
        .found    (n_found),
        .idx      (n_idx)
    );

    // Winner selection, fire qualification and source handshake
    always_comb begin
        winner     = u_found ? u_idx : n_idx;
        fire       = (state == FULL) && (u_found || n_found);
        src_ready  = !rst && ((state == EMPTY) || fire);
        ptr_next   = (winner == IDX_W'(N_CORES - 1)) ? '0 : winner + 1'b1;
        grant_next = '0;
        grant_next[winner] = 1'b1;
    end

    // Holding-buffer FSM with registered grant, data, index and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            buf_q      <= '0;
            core_grant <= '0;
            core_data  <= '0;
            grant_idx  <= '0;
            u_ptr      <= '0;
            n_ptr      <= '0;
        end else begin
            core_grant <= '0;
            if (fire) begin
                core_grant <= grant_next;
                grant_idx  <= winner;
                core_data  <= buf_q;
                if (u_found) begin
                    u_ptr <= ptr_next;
                end else begin
                    n_ptr <= ptr_next;
                end
            end
            // A reload during a fire keeps the buffer FULL for back-to-back flow
            if (src_valid && src_ready) begin
                buf_q <= src_data;
                state <= FULL;
            end else if (fire) begin
                state <= EMPTY;
            end
        end
    end

`ifdef SAMPLE_DISPATCHER_STATS_EN
    logic starve;

    // Stall with a full buffer where every requester is locked out
    always_comb begin
        starve = (state == FULL) && (|req_in) && !(u_found || n_found);
    end

    // Saturating dispatch and starvation counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dispatched <= '0;
            stat_starve     <= '0;
        end else begin
            if (fire && (stat_dispatched != '1)) begin
                stat_dispatched <= stat_dispatched + 32'd1;
            end
            if (starve && (stat_starve != '1)) begin
                stat_starve <= stat_starve + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_dispatcher.sv
// Directed table-driven bench for sample_dispatcher with N_CORES=4, DW=32.
module tb_sample_dispatcher;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*N-1:0]  req_in = '0;
    logic [DW-1:0]   src_data = '0;
    logic            src_valid = 1'b0;
    logic            src_ready;
    logic [DW-1:0]   core_data;
    logic [N-1:0]    core_grant;
    logic [IW-1:0]   grant_idx;
`ifdef SAMPLE_DISPATCHER_STATS_EN
    logic [31:0]     stat_dispatched;
    logic [31:0]     stat_starve;
`endif

    int checks = 0;
    int errors = 0;

    sample_dispatcher #(.N_CORES(N), .DW(DW), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .core_data  (core_data),
        .core_grant (core_grant),
        .grant_idx  (grant_idx)
`ifdef SAMPLE_DISPATCHER_STATS_EN
        ,
        .stat_dispatched (stat_dispatched),
        .stat_starve     (stat_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        sv;
        logic [31:0] sd;
        logic [7:0]  req;
        logic        rdy;
        logic [3:0]  g;
        logic [31:0] d;
        logic [1:0]  i;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic sv, input int sd, input logic [7:0] req,
                       input logic rdy, input logic [3:0] g, input int d, input logic [1:0] i);
        vec_t v;
        v.rst = r; v.sv = sv; v.sd = sd; v.req = req;
        v.rdy = rdy; v.g = g; v.d = d; v.i = i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Grant vector must never have more than one bit set
    always @(negedge clk) begin
        if (!rst) check("grant_onehot0", {31'b0, $onehot0(core_grant)}, 32'd1);
    end

    initial begin
        // rst sv  sd    req    rdy g     d     idx
        add(1, 0, 0,    8'h00, 0, 4'h0, 0,    0);  // reset state
        add(0, 1, -7,   8'h10, 1, 4'h0, 0,    0);  // capture -7, core2 normal
        add(0, 0, 0,    8'h10, 1, 4'h0, 0,    0);  // fire core2
        add(0, 0, 0,    8'h10, 1, 4'h4, -7,   2);  // grant visible
        add(0, 0, 0,    8'h00, 1, 4'h0, -7,   2);
        add(0, 1, 20,   8'h40, 1, 4'h0, -7,   2);  // capture 20, core3
        add(0, 1, 21,   8'h40, 1, 4'h0, -7,   2);  // fire core3, reload 21, n_ptr wraps
        add(0, 0, 0,    8'h00, 0, 4'h8, 20,   3);  // no request: hold
        add(0, 0, 0,    8'h41, 1, 4'h0, 20,   3);  // core0 vs core3 -> core0
        add(0, 0, 0,    8'h00, 1, 4'h1, 21,   0);
        add(1, 0, 0,    8'h00, 0, 4'h0, 0,    0);  // reset pointers
        add(0, 1, 10,   8'h45, 1, 4'h0, 0,    0);  // cores 0,1,3 streaming
        add(0, 1, 11,   8'h45, 1, 4'h0, 0,    0);
        add(0, 1, 12,   8'h45, 1, 4'h1, 10,   0);
        add(0, 1, 13,   8'h45, 1, 4'h2, 11,   1);
        add(0, 0, 0,    8'h45, 1, 4'h8, 12,   3);
        add(0, 0, 0,    8'h00, 1, 4'h1, 13,   0);
        add(0, 1, -100, 8'hC4, 1, 4'h0, 13,   0);  // core1 normal, core3 urgent
        add(0, 1, 200,  8'hC4, 1, 4'h0, 13,   0);
        add(0, 0, 0,    8'hC4, 1, 4'h8, -100, 3);
        add(0, 0, 0,    8'h00, 1, 4'h2, 200,  1);
        add(0, 1, 7,    8'h84, 1, 4'h0, 200,  1);  // n_ptr=2: core3 before core1
        add(0, 0, 0,    8'h84, 1, 4'h0, 200,  1);
        add(0, 0, 0,    8'h00, 1, 4'h8, 7,    3);
        add(0, 1, 8,    8'h33, 1, 4'h0, 7,    3);  // u_ptr=0: core0 before core2
        add(0, 0, 0,    8'h33, 1, 4'h0, 7,    3);
        add(0, 0, 0,    8'h00, 1, 4'h1, 8,    0);
        add(0, 1, 5,    8'h00, 1, 4'h0, 8,    0);  // capture 5, nobody requests
        for (int k = 0; k < 6; k++) add(0, 1, 66, 8'h00, 0, 4'h0, 8, 0);
        add(0, 0, 0,    8'h01, 1, 4'h0, 8,    0);  // core0 requests
        add(0, 0, 0,    8'h01, 1, 4'h1, 5,    0);
        add(0, 0, 0,    8'h01, 1, 4'h0, 5,    0);  // no duplicate

        repeat (2) @(posedge clk);
        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            rst       = vecs[k].rst;
            src_valid = vecs[k].sv;
            src_data  = vecs[k].sd;
            req_in    = vecs[k].req;
            #1;
            check($sformatf("v%0d src_ready", k), {31'b0, src_ready}, {31'b0, vecs[k].rdy});
            check($sformatf("v%0d core_grant", k), {28'b0, core_grant}, {28'b0, vecs[k].g});
            check($sformatf("v%0d core_data", k), core_data, vecs[k].d);
            check($sformatf("v%0d grant_idx", k), {30'b0, grant_idx}, {30'b0, vecs[k].i});
        end

        // Reset while FULL with 99 buffered and a grant pulse on the outputs
        @(posedge clk); #1;
        src_valid = 1'b1; src_data = 98; req_in = 8'h00;
        #1; check("rst_seq ready_a", {31'b0, src_ready}, 32'd1);
        @(posedge clk); #1;
        src_data = 99; req_in = 8'h04;
        #1; check("rst_seq ready_b", {31'b0, src_ready}, 32'd1);
        @(posedge clk); #1;
        src_valid = 1'b0;
        check("rst_seq grant_pre", {28'b0, core_grant}, 32'h2);
        check("rst_seq data_pre", core_data, 32'd98);
        rst = 1'b1;
        #1;
        check("rst_seq grant_async", {28'b0, core_grant}, 32'h0);
        check("rst_seq ready_rst", {31'b0, src_ready}, 32'd0);
        check("rst_seq data_rst", core_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1; check("rst_seq ready_post", {31'b0, src_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check($sformatf("rst_seq no_grant%0d", k), {28'b0, core_grant}, 32'h0);
            check($sformatf("rst_seq no_data%0d", k), core_data, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
